// File: rtl/wb_retire_unit_pkg.sv
// Shared widths, lane field offsets and stop encodings for the writeback retire stage.
// Pure declarations: no logic, no latency.
// No backpressure of its own; consumers derive widths from these helpers.
package wb_retire_unit_pkg;

    // ctrl stall encodings for mem_stop / wb_stop
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // One MEM->WB lane: {valid, pc, rf_we, waddr, wdata, hi_we, lo_we, hi, lo}
    function automatic int wb_lane_wd(input int xlen, input int rf_aw);
        return 1 + xlen + 1 + rf_aw + 3 * xlen + 2;
    endfunction

    // One WB->regfile lane: {we, waddr, wdata}
    function automatic int wb_to_rf_lane_wd(input int xlen, input int rf_aw);
        return 1 + rf_aw + xlen;
    endfunction

    // One trace entry: {pc, rf_we, waddr, wdata}
    function automatic int wb_trace_wd(input int xlen, input int rf_aw);
        return xlen + 1 + rf_aw + xlen;
    endfunction

    // Field LSB offsets inside one lane (lo sits in the lane LSBs)
    function automatic int wb_off_lo(input int xlen);
        return 0;
    endfunction
    function automatic int wb_off_hi(input int xlen);
        return xlen;
    endfunction
    function automatic int wb_off_lo_we(input int xlen);
        return 2 * xlen;
    endfunction
    function automatic int wb_off_hi_we(input int xlen);
        return 2 * xlen + 1;
    endfunction
    function automatic int wb_off_wdata(input int xlen);
        return 2 * xlen + 2;
    endfunction
    function automatic int wb_off_waddr(input int xlen);
        return 3 * xlen + 2;
    endfunction
    function automatic int wb_off_rf_we(input int xlen, input int rf_aw);
        return 3 * xlen + 2 + rf_aw;
    endfunction
    function automatic int wb_off_pc(input int xlen, input int rf_aw);
        return 3 * xlen + 3 + rf_aw;
    endfunction
    function automatic int wb_off_valid(input int xlen, input int rf_aw);
        return 4 * xlen + 3 + rf_aw;
    endfunction

    // Valid-lane count for up to four lanes
    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Trace FIFO: accepts up to PUSH_N entries per cycle (packed in ascending order), pops one.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none internally; the producer must check count against DEPTH before pushing.
// Ports: clk/resetn (sync, active-low), push_vld/push_dat (per-slot), pop (request),
//        head_vld/head_dat (zero when empty), count (occupancy).
module wb_trace_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    parameter  int PUSH_N = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PUSH_N-1:0]       push_vld,
    input  logic [PUSH_N*WIDTH-1:0] push_dat,
    input  logic                    pop,
    output logic                    head_vld,
    output logic [WIDTH-1:0]        head_dat,
    output logic [CW-1:0]           count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    slot [PUSH_N];
    logic [CW-1:0]    n_push;
    logic             pop_fire;

    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign pop_fire = pop & head_vld;

    // Valid slots are compacted: each takes the next free position after the lower valid slots.
    always_comb begin
        int off;
        off = 0;
        for (int i = 0; i < PUSH_N; i++) begin
            slot[i] = PW'((int'(wr_ptr) + off) % DEPTH);
            off     = off + int'(push_vld[i]);
        end
        n_push = CW'(off);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= PW'((int'(wr_ptr) + int'(n_push)) % DEPTH);
            rd_ptr <= PW'((int'(rd_ptr) + int'(pop_fire)) % DEPTH);
            count  <= count + n_push - CW'(pop_fire);
        end
    end

    // Storage needs no reset: head_dat is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_N; i++) begin
            if (push_vld[i]) begin
                mem[slot[i]] <= push_dat[i*WIDTH +: WIDTH];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) int'(count) <= DEPTH);

endmodule

// File: rtl/wb_retire_unit.sv
// Multi-lane writeback: registers the MEM->WB bundle, commits regfile/HI/LO writes once per bundle.
// Latency: writes are driven combinationally in the first cycle the held bundle can commit (0 cycles after the register).
// Backpressure: wb_stallreq holds the bundle while the trace FIFO lacks room for its valid lanes.
// Ports: clk/resetn (sync, active-low), mem_stop/wb_stop from ctrl, mem_to_wb_bus in,
//        wb_to_rf_bus / wb_to_hilo_bus out, wb_stallreq to ctrl, retire_cnt, debug_wb_* trace head.
module wb_retire_unit
    import wb_retire_unit_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int XLEN        = 32,
    parameter int RF_AW       = 5,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic                                          mem_stop,
    input  logic                                          wb_stop,
    input  logic [LANES*wb_lane_wd(XLEN, RF_AW)-1:0]      mem_to_wb_bus,
    output logic [LANES*wb_to_rf_lane_wd(XLEN, RF_AW)-1:0] wb_to_rf_bus,
    output logic [2+2*XLEN-1:0]                           wb_to_hilo_bus,
    output logic                                          wb_stallreq,
    output logic [31:0]                                   retire_cnt,
    output logic [XLEN-1:0]                               debug_wb_pc,
    output logic [3:0]                                    debug_wb_rf_wen,
    output logic [RF_AW-1:0]                              debug_wb_rf_wnum,
    output logic [XLEN-1:0]                               debug_wb_rf_wdata
);

    localparam int LW  = wb_lane_wd(XLEN, RF_AW);
    localparam int RFW = wb_to_rf_lane_wd(XLEN, RF_AW);
    localparam int TW  = wb_trace_wd(XLEN, RF_AW);
    localparam int CW  = $clog2(TRACE_DEPTH + 1);

    localparam int OFF_LO    = wb_off_lo(XLEN);
    localparam int OFF_HI    = wb_off_hi(XLEN);
    localparam int OFF_LO_WE = wb_off_lo_we(XLEN);
    localparam int OFF_HI_WE = wb_off_hi_we(XLEN);
    localparam int OFF_WDATA = wb_off_wdata(XLEN);
    localparam int OFF_WADDR = wb_off_waddr(XLEN);
    localparam int OFF_RF_WE = wb_off_rf_we(XLEN, RF_AW);
    localparam int OFF_PC    = wb_off_pc(XLEN, RF_AW);
    localparam int OFF_VALID = wb_off_valid(XLEN, RF_AW);

    logic [LANES*LW-1:0]    bundle_q;
    logic                   committed_q;
    logic [3:0]             vmask;
    logic [2:0]             need;
    logic [CW-1:0]          trace_cnt;
    logic [CW-1:0]          free;
    logic                   bundle_vld;
    logic                   need_gt_free;
    logic                   commit;
    logic [LW-1:0]          lane;
    logic                   hi_any;
    logic                   lo_any;
    logic [XLEN-1:0]        hi_dat;
    logic [XLEN-1:0]        lo_dat;
    logic [LANES-1:0]       push_vld;
    logic [LANES*TW-1:0]    push_dat;
    logic                   trace_vld;
    logic [TW-1:0]          trace_dat;
    logic                   head_rf_we;

    // ------------------------------------------------------------------
    // Commit / stall decision
    // ------------------------------------------------------------------
    always_comb begin
        vmask = '0;
        for (int i = 0; i < LANES; i++) begin
            vmask[i] = bundle_q[i*LW + OFF_VALID];
        end
    end

    assign need         = popcnt4(vmask);
    assign bundle_vld   = |vmask;
    assign free         = CW'(TRACE_DEPTH) - trace_cnt;
    assign need_gt_free = 32'(need) > 32'(free);
    assign commit       = bundle_vld & ~committed_q & ~need_gt_free;
    assign wb_stallreq  = bundle_vld & ~committed_q & need_gt_free;

    // ------------------------------------------------------------------
    // Bundle register. A stalled bundle must stay put even if ctrl says
    // MEM moved on, otherwise its lanes would be lost before they commit.
    // committed_q stops a bundle held by wb_stop from writing twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bundle_q    <= '0;
            committed_q <= 1'b0;
        end else if (wb_stallreq) begin
            bundle_q    <= bundle_q;
            committed_q <= committed_q;
        end else if (mem_stop == STOP && wb_stop == NO_STOP) begin
            bundle_q    <= '0;
            committed_q <= 1'b0;
        end else if (mem_stop == NO_STOP) begin
            bundle_q    <= mem_to_wb_bus;
            committed_q <= 1'b0;
        end else begin
            committed_q <= committed_q | commit;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retire_cnt <= '0;
        end else if (commit) begin
            retire_cnt <= retire_cnt + 32'(need);
        end
    end

    // ------------------------------------------------------------------
    // Per-lane outputs. HI and LO each take the highest-index enabling
    // lane, so the ascending loop lets later lanes overwrite earlier ones.
    // ------------------------------------------------------------------
    always_comb begin
        lane         = '0;
        wb_to_rf_bus = '0;
        hi_any       = 1'b0;
        lo_any       = 1'b0;
        hi_dat       = '0;
        lo_dat       = '0;
        push_vld     = '0;
        push_dat     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = bundle_q[i*LW +: LW];
            wb_to_rf_bus[i*RFW +: RFW] = {commit & lane[OFF_VALID] & lane[OFF_RF_WE],
                                          lane[OFF_WADDR +: RF_AW],
                                          lane[OFF_WDATA +: XLEN]};
            if (lane[OFF_VALID] && lane[OFF_HI_WE]) begin
                hi_any = 1'b1;
                hi_dat = lane[OFF_HI +: XLEN];
            end
            if (lane[OFF_VALID] && lane[OFF_LO_WE]) begin
                lo_any = 1'b1;
                lo_dat = lane[OFF_LO +: XLEN];
            end
            push_vld[i] = commit & lane[OFF_VALID];
            push_dat[i*TW +: TW] = {lane[OFF_PC +: XLEN], lane[OFF_RF_WE],
                                    lane[OFF_WADDR +: RF_AW], lane[OFF_WDATA +: XLEN]};
        end
    end

    assign wb_to_hilo_bus = {commit & hi_any, commit & lo_any, hi_dat, lo_dat};

    // ------------------------------------------------------------------
    // Debug trace: one retired lane per cycle from the FIFO head
    // ------------------------------------------------------------------
    wb_trace_fifo #(
        .WIDTH  (TW),
        .DEPTH  (TRACE_DEPTH),
        .PUSH_N (LANES)
    ) u_trace_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (1'b1),
        .head_vld (trace_vld),
        .head_dat (trace_dat),
        .count    (trace_cnt)
    );

    assign {debug_wb_pc, head_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} = trace_dat;
    assign debug_wb_rf_wen = {4{trace_vld & head_rf_we}};

endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int DEPTH = 2;
    localparam int LW    = 4 * XLEN + RF_AW + 4;
    localparam int BUSW  = LANES * LW;
    localparam int RFW   = 1 + RF_AW + XLEN;
    localparam int RFB   = LANES * RFW;
    localparam int HLW   = 2 + 2 * XLEN;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              mem_stop = 1'b0;
    logic              wb_stop = 1'b0;
    logic [BUSW-1:0]   mem_to_wb_bus = '0;
    logic [RFB-1:0]    wb_to_rf_bus;
    logic [HLW-1:0]    wb_to_hilo_bus;
    logic              wb_stallreq;
    logic [31:0]       retire_cnt;
    logic [XLEN-1:0]   debug_wb_pc;
    logic [3:0]        debug_wb_rf_wen;
    logic [RF_AW-1:0]  debug_wb_rf_wnum;
    logic [XLEN-1:0]   debug_wb_rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    wb_retire_unit #(
        .LANES       (LANES),
        .XLEN        (XLEN),
        .RF_AW       (RF_AW),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_stop          (mem_stop),
        .wb_stop           (wb_stop),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_to_hilo_bus    (wb_to_hilo_bus),
        .wb_stallreq       (wb_stallreq),
        .retire_cnt        (retire_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             ms;
        logic             ws;
        logic [BUSW-1:0]  bus;
        logic             full;   // compare whole rf bus, not just the we bits
        logic [RFB-1:0]   rf;
        logic [HLW-1:0]   hilo;
        logic             stall;
        logic [31:0]      retire;
        logic [31:0]      pc;
        logic [3:0]       wen;
        logic [4:0]       wnum;
        logic [31:0]      wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [LW-1:0] lane(input logic v, input logic [31:0] pc, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic hwe, input logic lwe,
                                           input logic [31:0] hi, input logic [31:0] lo);
        return {v, pc, we, wa, wd, hwe, lwe, hi, lo};
    endfunction

    function automatic logic [RFW-1:0] rfl(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        return {we, wa, wd};
    endfunction

    function automatic logic [HLW-1:0] hl(input logic hwe, input logic lwe,
                                          input logic [31:0] hi, input logic [31:0] lo);
        return {hwe, lwe, hi, lo};
    endfunction

    function automatic vec_t mk(input logic ms, input logic ws, input logic [BUSW-1:0] bus,
                                input logic full, input logic [RFB-1:0] rf, input logic [HLW-1:0] hilo,
                                input logic stall, input logic [31:0] retire, input logic [31:0] pc,
                                input logic [3:0] wen, input logic [4:0] wnum, input logic [31:0] wdata);
        vec_t v;
        v.ms = ms; v.ws = ws; v.bus = bus; v.full = full; v.rf = rf; v.hilo = hilo;
        v.stall = stall; v.retire = retire; v.pc = pc; v.wen = wen; v.wnum = wnum; v.wdata = wdata;
        return v;
    endfunction

    function automatic logic [1:0] rf_wes(input logic [RFB-1:0] x);
        return {x[2*RFW-1], x[RFW-1]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0]  a0, a1, b0, b1, c0, c1, d0, d1, e0, e1, h0, h1;
    logic [287:0]   rnd_wide;

    initial begin
        a0 = lane(1'b1, 32'hBFC00000, 1'b1, 5'd3,  32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
        a1 = lane(1'b1, 32'hBFC00004, 1'b1, 5'd4,  32'h22, 1'b0, 1'b0, 32'h0, 32'h0);
        b0 = lane(1'b1, 32'hBFC00008, 1'b1, 5'd5,  32'h33, 1'b0, 1'b0, 32'h0, 32'h0);
        b1 = lane(1'b1, 32'hBFC0000C, 1'b0, 5'd6,  32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        c0 = lane(1'b1, 32'h00001000, 1'b1, 5'd7,  32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
        c1 = lane(1'b1, 32'h00001004, 1'b1, 5'd8,  32'h66, 1'b0, 1'b0, 32'h0, 32'h0);
        d0 = lane(1'b1, 32'h00001008, 1'b1, 5'd9,  32'h77, 1'b0, 1'b0, 32'h0, 32'h0);
        d1 = lane(1'b1, 32'h0000100C, 1'b1, 5'd10, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0);
        e0 = lane(1'b1, 32'hDEAD0000, 1'b1, 5'd11, 32'h99, 1'b1, 1'b1, 32'h1, 32'h2);
        e1 = lane(1'b1, 32'hDEAD0004, 1'b1, 5'd12, 32'h9A, 1'b1, 1'b1, 32'h3, 32'h4);
        h0 = lane(1'b1, 32'h00000010, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 32'hA, 32'hC);
        h1 = lane(1'b1, 32'h00000014, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 32'hB, 32'hD);

        // ms, ws, bus, full, rf, hilo, stall, retire, pc, wen, wnum, wdata
        vecs.push_back(mk(1'b0, 1'b0, {a1, a0}, 1'b1, {rfl(1'b1, 5'd4, 32'h22), rfl(1'b1, 5'd3, 32'h11)}, '0, 1'b0, 32'd0, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, {a1, a0}, 1'b0, '0, '0, 1'b0, 32'd2, 32'hBFC00000, 4'hF, 5'd3, 32'h11));
        vecs.push_back(mk(1'b1, 1'b0, {a1, a0}, 1'b0, '0, '0, 1'b0, 32'd2, 32'hBFC00004, 4'hF, 5'd4, 32'h22));
        vecs.push_back(mk(1'b1, 1'b0, '0,       1'b0, '0, '0, 1'b0, 32'd2, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, {b1, b0}, 1'b1, {rfl(1'b0, 5'd6, 32'h44), rfl(1'b1, 5'd5, 32'h33)}, '0, 1'b0, 32'd2, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, {e1, e0}, 1'b0, '0, '0, 1'b0, 32'd4, 32'hBFC00008, 4'hF, 5'd5, 32'h33));
        vecs.push_back(mk(1'b1, 1'b1, {e1, e0}, 1'b0, '0, '0, 1'b0, 32'd4, 32'hBFC0000C, 4'h0, 5'd6, 32'h44));
        vecs.push_back(mk(1'b1, 1'b1, {e1, e0}, 1'b0, '0, '0, 1'b0, 32'd4, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, {c1, c0}, 1'b1, {rfl(1'b1, 5'd8, 32'h66), rfl(1'b1, 5'd7, 32'h55)}, '0, 1'b0, 32'd4, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, {d1, d0}, 1'b0, '0, '0, 1'b1, 32'd6, 32'h1000, 4'hF, 5'd7, 32'h55));
        vecs.push_back(mk(1'b0, 1'b0, {e1, e0}, 1'b0, '0, '0, 1'b1, 32'd6, 32'h1004, 4'hF, 5'd8, 32'h66));
        vecs.push_back(mk(1'b0, 1'b0, {e1, e0}, 1'b1, {rfl(1'b1, 5'd10, 32'h88), rfl(1'b1, 5'd9, 32'h77)}, '0, 1'b0, 32'd6, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, {e1, e0}, 1'b0, '0, '0, 1'b0, 32'd8, 32'h1008, 4'hF, 5'd9, 32'h77));
        vecs.push_back(mk(1'b1, 1'b0, '0,       1'b0, '0, '0, 1'b0, 32'd8, 32'h100C, 4'hF, 5'd10, 32'h88));
        vecs.push_back(mk(1'b1, 1'b0, '0,       1'b0, '0, '0, 1'b0, 32'd8, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, {h1, h0}, 1'b1, '0, hl(1'b1, 1'b1, 32'hB, 32'hC), 1'b0, 32'd8, 32'h0, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, '0,       1'b0, '0, '0, 1'b0, 32'd10, 32'h10, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, '0,       1'b0, '0, '0, 1'b0, 32'd10, 32'h14, 4'h0, 5'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, '0,       1'b0, '0, '0, 1'b0, 32'd10, 32'h0, 4'h0, 5'd0, 32'h0));

        // Reset held for two cycles with random inputs
        resetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 9; k++) rnd_wide[k*32 +: 32] = $urandom;
            mem_to_wb_bus = rnd_wide[BUSW-1:0];
            mem_stop = 1'($urandom_range(0, 1));
            wb_stop  = 1'($urandom_range(0, 1));
            step();
        end
        check("reset rf",     128'(wb_to_rf_bus),      128'(0));
        check("reset hilo",   128'(wb_to_hilo_bus),    128'(0));
        check("reset stall",  128'(wb_stallreq),       128'(0));
        check("reset retire", 128'(retire_cnt),        128'(0));
        check("reset pc",     128'(debug_wb_pc),       128'(0));
        check("reset wen",    128'(debug_wb_rf_wen),   128'(0));
        check("reset wnum",   128'(debug_wb_rf_wnum),  128'(0));
        check("reset wdata",  128'(debug_wb_rf_wdata), 128'(0));
        resetn = 1'b1;

        foreach (vecs[i]) begin
            mem_stop      = vecs[i].ms;
            wb_stop       = vecs[i].ws;
            mem_to_wb_bus = vecs[i].bus;
            step();
            if (vecs[i].full)
                check($sformatf("v%0d rf", i), 128'(wb_to_rf_bus), 128'(vecs[i].rf));
            else
                check($sformatf("v%0d rf_we", i), 128'(rf_wes(wb_to_rf_bus)), 128'(rf_wes(vecs[i].rf)));
            if (vecs[i].hilo[HLW-1 -: 2] != 2'b00)
                check($sformatf("v%0d hilo", i), 128'(wb_to_hilo_bus), 128'(vecs[i].hilo));
            else
                check($sformatf("v%0d hilo_we", i), 128'(wb_to_hilo_bus[HLW-1 -: 2]), 128'(vecs[i].hilo[HLW-1 -: 2]));
            check($sformatf("v%0d stall", i),  128'(wb_stallreq),       128'(vecs[i].stall));
            check($sformatf("v%0d retire", i), 128'(retire_cnt),        128'(vecs[i].retire));
            check($sformatf("v%0d pc", i),     128'(debug_wb_pc),       128'(vecs[i].pc));
            check($sformatf("v%0d wen", i),    128'(debug_wb_rf_wen),   128'(vecs[i].wen));
            check($sformatf("v%0d wnum", i),   128'(debug_wb_rf_wnum),  128'(vecs[i].wnum));
            check($sformatf("v%0d wdata", i),  128'(debug_wb_rf_wdata), 128'(vecs[i].wdata));
        end

        // Reset while the second of two back-to-back bundles is stalled
        mem_stop = 1'b0;
        wb_stop  = 1'b0;
        mem_to_wb_bus = {c1, c0};
        step();
        check("rst_stall commit rf", 128'(wb_to_rf_bus), 128'({rfl(1'b1, 5'd8, 32'h66), rfl(1'b1, 5'd7, 32'h55)}));
        mem_to_wb_bus = {d1, d0};
        step();
        check("rst_stall stall",  128'(wb_stallreq),            128'(1));
        check("rst_stall rf_we",  128'(rf_wes(wb_to_rf_bus)),   128'(0));
        check("rst_stall retire", 128'(retire_cnt),             128'(12));
        resetn = 1'b0;
        mem_to_wb_bus = {e1, e0};
        step();
        check("rst_stall post rf",     128'(wb_to_rf_bus),    128'(0));
        check("rst_stall post hilo",   128'(wb_to_hilo_bus),  128'(0));
        check("rst_stall post stall",  128'(wb_stallreq),     128'(0));
        check("rst_stall post retire", 128'(retire_cnt),      128'(0));
        check("rst_stall post pc",     128'(debug_wb_pc),     128'(0));
        check("rst_stall post wen",    128'(debug_wb_rf_wen), 128'(0));
        resetn   = 1'b1;
        mem_stop = 1'b1;
        wb_stop  = 1'b1;
        step();
        check("rst_stall flushed pc",     128'(debug_wb_pc),           128'(0));
        check("rst_stall flushed rf_we",  128'(rf_wes(wb_to_rf_bus)),  128'(0));
        check("rst_stall flushed retire", 128'(retire_cnt),            128'(0));
        check("rst_stall flushed stall",  128'(wb_stallreq),           128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
